// File: rtl/prll_bs_rr_arbtr.sv
// Round-robin shared-bus arbiter: pops one word from a pending driver FIFO and
// routes it to one driver (by destination ID in the MSBs), broadcasts it, or drops it.
module prll_bs_rr_arbtr_lane #(
  parameter int bits = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_ld,
  input  logic            i_push,
  input  logic [bits-1:0] i_pkt,
  output logic            o_push,
  output logic [bits-1:0] o_dpush
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_push  <= 1'b0;
      o_dpush <= '0;
    end else begin
      o_push <= i_push;
      if (i_ld) o_dpush <= i_pkt;
    end
  end
endmodule

module prll_bs_rr_arbtr #(
  parameter int                 bits      = 32,
  parameter int                 drvrs     = 4,
  parameter int                 id_bits   = 8,
  parameter logic [id_bits-1:0] broadcast = {id_bits{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [drvrs-1:0]      pndng,
  input  logic [drvrs*bits-1:0] D_pop,
  output logic [drvrs-1:0]      pop,
  output logic [drvrs-1:0]      push,
  output logic [drvrs*bits-1:0] D_push,
  output logic                  busy,
  output logic [((drvrs > 1) ? $clog2(drvrs) : 1)-1:0] grant,
  output logic [15:0]           drop_cnt
);
  localparam int gw = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t                        r_state, w_state_nxt;
  logic [gw-1:0]                 r_grant, r_last, w_nxt_grant;
  logic                          w_found;
  logic [bits-1:0]               r_pkt;
  logic [drvrs-1:0]              r_pop, w_push_sel;
  logic                          r_busy;
  logic [15:0]                   r_drop_cnt;
  logic [id_bits-1:0]            w_dst;
  logic                          w_bcast, w_ucast, w_ld;
  logic [drvrs-1:0][bits-1:0]    w_dpop;

  assign w_dpop = D_pop;

  // Search starts one past the last served driver so each pending driver waits at most drvrs transfers.
  always_comb begin
    w_found     = 1'b0;
    w_nxt_grant = r_last;
    for (int k = 1; k <= drvrs; k++) begin
      if (!w_found && pndng[(int'(r_last) + k) % drvrs]) begin
        w_found     = 1'b1;
        w_nxt_grant = gw'((int'(r_last) + k) % drvrs);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_found) w_state_nxt = POP;
      POP:     w_state_nxt = PUSH;
      PUSH:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Broadcast wins over unicast even when its ID would be a valid driver index.
  assign w_dst   = r_pkt[bits-1 -: id_bits];
  assign w_bcast = (w_dst == broadcast);
  assign w_ucast = !w_bcast && (32'(w_dst) < 32'(drvrs));
  assign w_ld    = (r_state == PUSH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_last     <= gw'(drvrs - 1);
      r_pkt      <= '0;
      r_pop      <= '0;
      r_busy     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pop   <= '0;
      case (r_state)
        IDLE: if (w_found) begin
          r_grant <= w_nxt_grant;
          r_busy  <= 1'b1;
        end
        POP: begin
          r_pop[r_grant] <= 1'b1;
          r_pkt          <= w_dpop[r_grant];
        end
        PUSH: begin
          r_last <= r_grant;
          r_busy <= 1'b0;
          if (!w_bcast && !w_ucast && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  for (genvar j = 0; j < drvrs; j++) begin : g_lane
    assign w_push_sel[j] = w_ld && (w_bcast ? (r_grant != gw'(j)) : (w_ucast && (32'(w_dst) == j)));

    prll_bs_rr_arbtr_lane #(.bits(bits)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_ld    (w_ld),
      .i_push  (w_push_sel[j]),
      .i_pkt   (r_pkt),
      .o_push  (push[j]),
      .o_dpush (D_push[j*bits +: bits])
    );
  end

  assign pop      = r_pop;
  assign busy     = r_busy;
  assign grant    = r_grant;
  assign drop_cnt = r_drop_cnt;
endmodule

// File: doc/prll_bs_rr_arbtr.md
Name: prll_bs_rr_arbtr

Overview:
Parametrised shared-bus arbiter and packet router for the parallel bus interface. It connects `drvrs` FIFO-backed drivers to one bus, with flattened vector ports sized from `drvrs` and `bits` and no per-instance wrapper. Round-robin arbitration picks a pending driver, pops one word from it, decodes the destination ID in the word's MSBs, and pushes the word to one driver or broadcasts it. The block also drops words with an unknown destination, counts the drops, and exports bus status.

Parameters:
bits, 32, payload word width; must be > id_bits
drvrs, 4, number of drivers on the bus; 2..16
id_bits, 8, width of the destination ID field at D[bits-1 -: id_bits]
broadcast, {8{1'b1}}, ID value meaning "all drivers except source"; id_bits wide
gw, $clog2(drvrs) (min 1), derived width of driver indices

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pndng  in  drvrs  bit i=1: driver i FIFO non-empty; head word valid on D_pop
D_pop  in  drvrs*bits  slice i = head word of driver i FIFO (first-word-fall-through)
pop  out  drvrs  one-cycle pop strobe to driver i FIFO
push  out  drvrs  one-cycle push strobe to driver i input FIFO
D_push  out  drvrs*bits  slice i = word being pushed to driver i
busy  out  1  high while a transfer is in progress (state != IDLE)
grant  out  gw  index of the driver currently or last granted
drop_cnt  out  16  saturating count of dropped words

Behaviour:
- Reset (reset=0, async): state=IDLE; pop, push, busy, grant, drop_cnt all 0; D_push=0; packet register cleared; rr pointer last=drvrs-1, so driver 0 has first priority. A transfer in flight at reset is abandoned; a word already popped is lost.
- All outputs are registered; no combinational path from an input to an output.
- FSM states: IDLE, POP, PUSH.
- IDLE:
  - If pndng==0, stay in IDLE.
  - Otherwise grant <= the first i with pndng[i]=1, searching last+1, last+2, ... modulo drvrs. Then busy<=1 and go to POP.
- POP:
  - pop[grant]=1 for exactly this cycle; all other pop bits are 0.
  - pkt <= D_pop slice[grant]; decode dst = pkt[bits-1 -: id_bits]. Go to PUSH.
  - pndng is not re-checked in POP (the grant was based on IDLE sampling).
- PUSH (one cycle), with all D_push slices = pkt:
  - dst==broadcast: push[j]=1 for every j != grant.
  - dst<drvrs: push[dst]=1. dst==grant is allowed (loopback).
  - Otherwise: push=0 and drop_cnt += 1, saturating at 16'hFFFF.
  - Every case: last <= grant; busy deasserts on the next cycle; go to IDLE.
- Timing: pop lands 2 clk after pndng is seen in IDLE; push lands 1 clk after pop. Throughput is one word per 3 cycles.
- Fairness: a driver that stays pending is served within drvrs transfers.
- broadcast takes precedence when broadcast < drvrs (that ID is not a unicast address).
- Downstream FIFO full is not handled: push is fire-and-forget, and the sink FIFO must be deep enough.
- Outside PUSH, push=0 and D_push holds its last value.

Test Plan:
1. Reset then idle: reset low for 3 cycles, pndng=0 → pop=0, push=0, busy=0, grant=0, drop_cnt=0 for 20 cycles.
2. Unicast: drvrs=4, pndng=4'b0010, D_pop[1]=32'h02_00ABCD → pop=4'b0010 exactly 2 cycles after pndng is seen, push=4'b0100 the next cycle, D_push[2]=32'h02_00ABCD.
3. Round-robin: pndng=4'b1111 held; all words addressed to driver 0 → grant sequence 0,1,2,3,0; pop one-hot each time, one pop per 3 cycles.
4. Broadcast: driver 3 sends 32'hFF_123456 → push=4'b0111 in a single cycle, all slices = 32'hFF_123456; push[3]=0.
5. Drop and saturation: driver 0 sends ID 8'h09 with drvrs=4 → pop occurs, push=0, drop_cnt 0→1. Then force drop_cnt=16'hFFFF and send one more bad word → count stays 16'hFFFF.
6. Reset mid-transfer: assert reset in POP → pop, push, busy drop to 0 immediately (async); after release, last=drvrs-1 and the next grant goes to the lowest pending index.
